// File: rtl/pifo_deq_ctrl.sv
// Enqueue/dequeue controller in front of pifo_reg: turns accepted upstream entries into inserts
// and pops the settled minimum-rank head into a one-entry output register.
module pifo_deq_ctrl #(
    parameter int unsigned L2_MAX_SIZE = 3,
    parameter int unsigned MAX_SIZE    = 2 ** L2_MAX_SIZE,
    parameter int unsigned RANK_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [RANK_WIDTH-1:0]  enq_rank,
    input  logic [META_WIDTH-1:0]  enq_meta,
    output logic                   pifo_insert,
    output logic                   pifo_remove,
    output logic [RANK_WIDTH-1:0]  pifo_rank_in,
    output logic [META_WIDTH-1:0]  pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]  pifo_rank_out,
    input  logic [META_WIDTH-1:0]  pifo_meta_out,
    input  logic                   pifo_valid_out,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [RANK_WIDTH-1:0]  deq_rank,
    output logic [META_WIDTH-1:0]  deq_meta,
    output logic [L2_MAX_SIZE:0]   occupancy,
    output logic                   err
);

    typedef enum logic [1:0] {StIdle, StSettle, StHead} state_e;

    localparam logic [L2_MAX_SIZE:0] Cap    = (L2_MAX_SIZE + 1)'(MAX_SIZE - 1);
    localparam logic [L2_MAX_SIZE:0] OccOne = (L2_MAX_SIZE + 1)'(1);

    state_e                 state_q;
    logic [1:0]             settle_q;
    logic [L2_MAX_SIZE:0]   occ_q;
    logic                   deq_valid_q;
    logic [RANK_WIDTH-1:0]  deq_rank_q;
    logic [META_WIDTH-1:0]  deq_meta_q;
    logic                   err_q;

    logic                   drain;
    logic                   pop;
    logic                   cmd;
    logic [1:0]             settle_now;
    logic [1:0]             settle_next;
    logic [L2_MAX_SIZE:0]   occ_next;

    assign drain       = (occ_q != '0) && (!deq_valid_q || deq_ready);
    assign pop         = !rst && (state_q == StHead) && drain && pifo_valid_out;
    // Dequeue wins over enqueue so the settle window can close while draining.
    assign enq_ready   = !rst && (occ_q < Cap) && !drain;
    assign pifo_insert = enq_valid && enq_ready;
    assign pifo_remove = pop;
    assign cmd         = pifo_insert || pifo_remove;

    assign pifo_rank_in = enq_rank;
    assign pifo_meta_in = enq_meta;
    assign deq_valid    = deq_valid_q;
    assign deq_rank     = deq_rank_q;
    assign deq_meta     = deq_meta_q;
    assign occupancy    = occ_q;
    assign err          = err_q;

    // The command cycle itself counts as the first of the two settle cycles.
    always_comb begin
        settle_now  = cmd ? 2'd2 : settle_q;
        settle_next = (settle_now == 2'd0) ? 2'd0 : settle_now - 2'd1;
        occ_next    = occ_q;
        if (pifo_insert) begin
            occ_next = occ_q + OccOne;
        end else if (pop) begin
            occ_next = occ_q - OccOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= 2'd0;
            occ_q       <= '0;
            deq_valid_q <= 1'b0;
            deq_rank_q  <= '0;
            deq_meta_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            settle_q <= settle_next;
            occ_q    <= occ_next;
            if (settle_next != 2'd0) begin
                state_q <= StSettle;
            end else if (occ_next != '0) begin
                state_q <= StHead;
            end else begin
                state_q <= StIdle;
            end
            if (pop) begin
                deq_valid_q <= 1'b1;
                deq_rank_q  <= pifo_rank_out;
                deq_meta_q  <= pifo_meta_out;
            end else if (deq_ready) begin
                deq_valid_q <= 1'b0;
            end
            if ((state_q == StHead) && drain && !pifo_valid_out) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pifo_deq_ctrl.sv
// Bench for pifo_deq_ctrl: a queue-based pifo_reg stand-in plus a timestamp-based reference
// model of the controller, exercised by directed scenarios and a randomized run.
module tb_pifo_deq_ctrl;

    localparam int unsigned MaxSize = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq_valid, enq_ready;
    logic [7:0] enq_rank, enq_meta;
    logic       pifo_insert, pifo_remove;
    logic [7:0] pifo_rank_in, pifo_meta_in;
    logic [7:0] pifo_rank_out, pifo_meta_out;
    logic       pifo_valid_out;
    logic       deq_valid, deq_ready;
    logic [7:0] deq_rank, deq_meta;
    logic [3:0] occupancy;
    logic       err;

    always #5 clk = ~clk;

    pifo_deq_ctrl #(
        .L2_MAX_SIZE(3),
        .MAX_SIZE   (8),
        .RANK_WIDTH (8),
        .META_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_rank      (enq_rank),
        .enq_meta      (enq_meta),
        .pifo_insert   (pifo_insert),
        .pifo_remove   (pifo_remove),
        .pifo_rank_in  (pifo_rank_in),
        .pifo_meta_in  (pifo_meta_in),
        .pifo_rank_out (pifo_rank_out),
        .pifo_meta_out (pifo_meta_out),
        .pifo_valid_out(pifo_valid_out),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_rank      (deq_rank),
        .deq_meta      (deq_meta),
        .occupancy     (occupancy),
        .err           (err)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state: pifo contents as a sorted queue, output register, and command timestamps.
    logic [7:0] q_rank[$];
    logic [7:0] q_meta[$];
    logic [7:0] out_log[$];
    bit         m_dv = 1'b0;
    logic [7:0] m_rank = 8'h0;
    logic [7:0] m_meta = 8'h0;
    bit         m_err = 1'b0;
    int         last_cmd = -10;
    int         cyc = 0;
    bit         drop_head = 1'b0;

    // Observations from the most recent step.
    bit acc, popd;
    logic s_ready, s_insert, s_remove;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_pifo();
        if (q_rank.size() == 0) begin
            pifo_valid_out = 1'b0;
            pifo_rank_out  = 8'($urandom);
            pifo_meta_out  = 8'($urandom);
        end else if (cyc - last_cmd < 2) begin
            // Minimum still being recomputed: present garbage.
            pifo_valid_out = 1'($urandom_range(0, 1));
            pifo_rank_out  = 8'($urandom);
            pifo_meta_out  = 8'($urandom);
        end else begin
            pifo_valid_out = !drop_head;
            pifo_rank_out  = q_rank[0];
            pifo_meta_out  = q_meta[0];
        end
    endtask

    task automatic step(input bit ev, input logic [7:0] r, input logic [7:0] m, input bit dr,
                        input bit rs);
        bit fresh, drain, e_ready, e_pop, e_errset;
        int k;
        @(negedge clk);
        rst       = rs;
        enq_valid = ev;
        enq_rank  = r;
        enq_meta  = m;
        deq_ready = dr;
        #1;
        fresh    = (cyc - last_cmd) >= 2;
        drain    = (q_rank.size() > 0) && (!m_dv || dr);
        e_ready  = !rs && (q_rank.size() < MaxSize - 1) && !drain;
        acc      = ev && e_ready;
        e_pop    = !rs && fresh && drain && pifo_valid_out;
        e_errset = !rs && fresh && drain && !pifo_valid_out;
        popd     = e_pop;
        s_ready  = enq_ready;
        s_insert = pifo_insert;
        s_remove = pifo_remove;
        check_eq("enq_ready", enq_ready, e_ready);
        check_eq("pifo_insert", pifo_insert, acc);
        check_eq("pifo_remove", pifo_remove, e_pop);
        check_eq("pifo_rank_in", pifo_rank_in, r);
        check_eq("deq_valid", deq_valid, m_dv);
        check_eq("deq_rank", deq_rank, m_rank);
        check_eq("deq_meta", deq_meta, m_meta);
        check_eq("occupancy", occupancy, q_rank.size());
        check_eq("err", err, m_err);
        if (deq_valid && dr) out_log.push_back(deq_rank);
        @(posedge clk);
        #1;
        if (rs) begin
            q_rank.delete();
            q_meta.delete();
            m_dv = 1'b0; m_rank = 8'h0; m_meta = 8'h0; m_err = 1'b0;
            last_cmd = -10;
        end else begin
            if (e_pop) begin
                m_rank = q_rank.pop_front();
                m_meta = q_meta.pop_front();
                m_dv   = 1'b1;
            end else if (m_dv && dr) begin
                m_dv = 1'b0;
            end
            if (e_errset) m_err = 1'b1;
            if (acc) begin
                k = 0;
                while (k < q_rank.size() && q_rank[k] <= r) k++;
                q_rank.insert(k, r);
                q_meta.insert(k, m);
            end
            if (acc || e_pop) last_cmd = cyc;
        end
        cyc++;
        drive_pifo();
    endtask

    task automatic offer(input logic [7:0] r, input logic [7:0] m, input bit dr, output int n);
        n = 0;
        do begin
            step(1'b1, r, m, dr, 1'b0);
            n++;
        end while (!acc && n < 50);
        check_eq("offer_accepted", acc, 1);
    endtask

    initial begin
        int n;
        bit found;
        logic [7:0] held_rank, held_meta;
        rst = 1'b1; enq_valid = 1'b1; enq_rank = 8'h0; enq_meta = 8'h0; deq_ready = 1'b0;
        pifo_valid_out = 1'b0; pifo_rank_out = 8'h0; pifo_meta_out = 8'h0;
        @(posedge clk);
        #1;
        // Second reset cycle, still offering: nothing may be inserted.
        step(1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
        check_eq("reset_insert", s_insert, 0);

        // Single entry, first cycle after release.
        step(1'b1, 8'd5, 8'hA1, 1'b1, 1'b0);
        check_eq("post_reset_ready", s_ready, 1);
        check_eq("single_insert_t0", s_insert, 1);
        step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
        check_eq("single_remove_t1", s_remove, 0);
        step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
        check_eq("single_remove_t2", s_remove, 1);
        check_eq("single_dv_t3", deq_valid, 1);
        check_eq("single_rank_t3", deq_rank, 8'd5);
        check_eq("single_meta_t3", deq_meta, 8'hA1);
        check_eq("single_occ_t3", occupancy, 0);
        repeat (3) step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);

        // Ordering: 9 is popped alone, then 3,7,1 queue up behind it.
        offer(8'd9, 8'h09, 1'b0, n);
        offer(8'd3, 8'h03, 1'b0, n);
        offer(8'd7, 8'h07, 1'b0, n);
        offer(8'd1, 8'h01, 1'b0, n);
        check_eq("order_occ", occupancy, 3);
        check_eq("order_head", deq_rank, 8'd9);
        out_log.delete();
        repeat (15) step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
        check_eq("order_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check_eq("order_0", out_log[0], 8'd9);
            check_eq("order_1", out_log[1], 8'd1);
            check_eq("order_2", out_log[2], 8'd3);
            check_eq("order_3", out_log[3], 8'd7);
        end

        // Full: 10 goes to the output register, 11..17 fill pifo_reg, 18 is held off.
        for (int i = 10; i <= 17; i++) offer(8'(i), 8'(i + 8'h80), 1'b0, n);
        repeat (3) begin
            step(1'b1, 8'd18, 8'h92, 1'b0, 1'b0);
            check_eq("full_ready", s_ready, 0);
        end
        check_eq("full_occ", occupancy, 7);
        check_eq("full_head", deq_rank, 8'd10);
        step(1'b1, 8'd18, 8'h92, 1'b1, 1'b0);
        check_eq("full_pop", s_remove, 1);
        check_eq("full_replace", deq_rank, 8'd11);
        check_eq("full_replace_dv", deq_valid, 1);
        offer(8'd18, 8'h92, 1'b0, n);
        check_eq("full_accept_18", n, 1);

        // Stall with the register full and downstream blocked.
        held_rank = deq_rank;
        held_meta = deq_meta;
        repeat (10) step(1'b1, 8'd19, 8'h93, 1'b0, 1'b0);
        check_eq("stall_rank", deq_rank, held_rank);
        check_eq("stall_meta", deq_meta, held_meta);
        check_eq("stall_occ", occupancy, 7);

        // Mid-operation reset right after a pop that leaves 4 entries.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
            if (popd && q_rank.size() == 4) found = 1'b1;
        end
        check_eq("midop_reached", found, 1);
        step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1);
        check_eq("midop_remove", s_remove, 0);
        check_eq("midop_dv", deq_valid, 0);
        check_eq("midop_occ", occupancy, 0);
        check_eq("midop_err", err, 0);

        // Randomized traffic with occasional missing heads and resets.
        for (int i = 0; i < 1500; i++) begin
            drop_head = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), 8'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end
        drop_head = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
